seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised successor to the 4-bit-operand tile ALU. It accepts one operation at a time through a valid/ready handshake. Add, subtract and logic ops complete in one cycle; multiply and divide are iterative, one bit per cycle. It returns a double-width result plus zero/carry/error flags, and sits between the tile's input pins and output mux as the tile's arithmetic engine.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..16.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request; high only in IDLE.
- op  in  3  operation code, sampled on accept.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  2*WIDTH  result; held stable while out_valid=1.
- flag_zero  out  1  result == 0 (all 2*WIDTH bits).
- flag_carry  out  1  carry (add) or borrow (sub); 0 for all other ops.
- flag_err  out  1  divide by zero, or divide op compiled out.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. A, B and op are latched; the inputs are don't-care afterwards.
- Ops, all unsigned:
  - 000 a+b
  - 001 a−b
  - 010 b−a
  - 011 a*b
  - 100 a/b
  - 101 b/a
  - 110 a&b
  - 111 a|b
- Add/sub/logic:
  - result[WIDTH-1:0] = value mod 2^WIDTH; upper half 0.
  - Add: flag_carry = bit WIDTH of the sum. Sub: flag_carry = 1 when the minuend is less than the subtrahend.
- Multiply: shift-add over WIDTH iterations; result = full 2*WIDTH product.
- Divide: restoring division over WIDTH iterations; result = {remainder, quotient}.
- Divide by zero (divisor == 0): no iteration. quotient = all ones, remainder = dividend, flag_err=1.
- FSM states:
  - IDLE: on accept, go to MUL for op 011. Go to DIV for op 100/101 with nonzero divisor. Otherwise compute and go to DONE.
  - MUL / DIV: iteration counter runs 0..WIDTH−1. After the last iteration, register the result and go to DONE.
  - DONE: stay until out_ready=1, then go to IDLE.
- Flags are registered together with result and remain valid for the whole DONE period.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, counter 0.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.

## Timing
- Accept at edge N for add/sub/logic, divide-by-zero, or compiled-out divide: out_valid=1 after edge N+1.
- Accept at edge N for multiply or divide: out_valid=1 after edge N+WIDTH+1.
- in_ready=0 from the accept edge until the edge where DONE is left with out_ready=1. in_ready is combinational from state.
- Throughput without backpressure: one single-cycle op every 2 cycles.
- If out_ready is held high in advance, DONE lasts exactly one cycle.
- A new request is not accepted in the same cycle that a result is consumed.

## Configuration
- SEQ_ALU_DIV_EN defined: the divider datapath and the DIV state are built, and ops 100/101 behave as above.
- SEQ_ALU_DIV_EN undefined: no divider logic is built. Ops 100/101 go IDLE→DONE in one cycle with result=0, flag_zero=1, flag_err=1.

## Structure
- Package seq_alu_pkg holds:
  - the op-code constants (OP_ADD … OP_OR);
  - the state enum (IDLE, MUL, DIV, DONE);
  - the iteration-counter width function clog2(WIDTH+1).
- Sub-module seq_alu_divider:
  - interface: start, dividend, divisor, done, quotient, remainder, counter;
  - instantiated only under SEQ_ALU_DIV_EN;
  - the top-level FSM waits on done.
- The multiplier stays inline in the top level.

## Test plan
All cases run with WIDTH=8.
- Add: a=200, b=100, op=000 → after 1 cycle, result=0x002C, flag_carry=1, flag_zero=0.
- Subtract: a=5, b=7, op=001 → result=0x00FE, flag_carry=1. Same operands with op=010 → result=0x0002, flag_carry=0.
- Multiply: a=200, b=200, op=011 → out_valid exactly 9 cycles after accept, result=0x9C40. Then a=0, b=55 → result=0, flag_zero=1.
- Divide: a=100, b=7, op=100 → result=0x020E after 9 cycles. Then a=9, b=0, op=100 → result=0x09FF, flag_err=1 after 1 cycle. With SEQ_ALU_DIV_EN undefined → result=0, flag_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → result and flags stay stable, in_ready=0, and in_valid pulses are ignored. Release out_ready → in_ready=1 on the next cycle.
- Reset mid-multiply: assert rst_n=0 at iteration 4 → out_valid=0, result=0, in_ready=1 immediately. A fresh 3*4 request then returns 0x000C.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: op codes, FSM state encoding and the
// iteration-counter width helper.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_RSUB = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_RDIV = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. Only built when
// SEQ_ALU_DIV_EN is defined; done/quotient/remainder describe the final step.
`ifdef SEQ_ALU_DIV_EN
module seq_alu_divider
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [CW-1:0]    counter
);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, dsor_q};
    rem_nx  = fits ? WIDTH'(shifted - {1'b0, dsor_q}) : shifted[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], fits};
  end

  always_comb begin
    done      = busy_q && (cnt_q == CW'(WIDTH - 1));
    quotient  = quo_nx;
    remainder = rem_nx;
    counter   = cnt_q;
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsor_d = dsor_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dsor_d = divisor;
    end else if (busy_q) begin
      rem_d  = rem_nx;
      quo_d  = quo_nx;
      cnt_d  = done ? '0 : cnt_q + 1'b1;
      busy_d = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsor_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsor_q <= dsor_d;
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// Sequential ALU: one op at a time via valid/ready, iterative multiply and
// (when SEQ_ALU_DIV_EN is defined) iterative divide, double-width result.
//
// Handshake: a request is taken on a rising edge with in_valid && in_ready;
// a result is taken on a rising edge with out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, so accept and consume never
// share a cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);

  if (WIDTH < 2 || WIDTH > 16) begin : g_width_chk
    $error("seq_alu: WIDTH must be in 2..16");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]   result_q, result_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;

  logic            accept;
  logic            last_iter;
  logic [W2-1:0]   acc_next;
  logic [WIDTH:0]  sum;
  logic [W2-1:0]   s_res;
  logic            s_carry;
  logic            s_err;

  assign accept    = in_valid && (state_q == IDLE);
  assign last_iter = cnt_q == CW'(WIDTH - 1);

`ifdef SEQ_ALU_DIV_EN
  logic             is_div;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [CW-1:0]    div_cnt;

  assign is_div    = (op == OP_DIV) || (op == OP_RDIV);
  assign dividend  = (op == OP_DIV) ? a : b;
  assign divisor   = (op == OP_DIV) ? b : a;
  assign div_start = accept && is_div && (divisor != '0);

  seq_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .counter   (div_cnt)
  );
`endif

  // Single-cycle results; divide rows here only cover the no-iteration cases.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    s_res   = '0;
    s_carry = 1'b0;
    s_err   = 1'b0;
    case (op)
      OP_ADD: begin
        s_res[WIDTH-1:0] = sum[WIDTH-1:0];
        s_carry          = sum[WIDTH];
      end
      OP_SUB: begin
        s_res[WIDTH-1:0] = a - b;
        s_carry          = a < b;
      end
      OP_RSUB: begin
        s_res[WIDTH-1:0] = b - a;
        s_carry          = b < a;
      end
      OP_MUL: s_res = '0;
      OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
        s_res = {a, {WIDTH{1'b1}}};
`endif
        s_err = 1'b1;
      end
      OP_RDIV: begin
`ifdef SEQ_ALU_DIV_EN
        s_res = {b, {WIDTH{1'b1}}};
`endif
        s_err = 1'b1;
      end
      OP_AND: s_res[WIDTH-1:0] = a & b;
      OP_OR:  s_res[WIDTH-1:0] = a | b;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) state_d = MUL;
`ifdef SEQ_ALU_DIV_EN
          else if (is_div && (divisor != '0)) state_d = DIV;
`endif
          else state_d = DONE;
        end
      end
      MUL: if (last_iter) state_d = DONE;
      DIV: begin
`ifdef SEQ_ALU_DIV_EN
        if (div_done) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: if (out_ready) state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    result     = result_q;
    flag_zero  = zero_q;
    flag_carry = carry_q;
    flag_err   = err_q;
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Datapath: operand capture, shift-add multiply, result/flag registration.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          result_d = s_res;
          zero_d   = (s_res == '0);
          carry_d  = s_carry;
          err_d    = s_err;
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          cnt_d    = '0;
          result_d = acc_next;
          zero_d   = (acc_next == '0);
          carry_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      DIV: begin
`ifdef SEQ_ALU_DIV_EN
        // Mirror the divider's counter so the iteration count stays visible here.
        cnt_d = div_cnt;
        if (div_done) begin
          cnt_d    = '0;
          result_d = {div_rem, div_quo};
          zero_d   = ({div_rem, div_quo} == '0);
          carry_d  = 1'b0;
          err_d    = 1'b0;
        end
`endif
      end
      DONE: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); divide expectations
// follow whether SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           flag_zero;
  logic           flag_carry;
  logic           flag_err;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_err   (flag_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for out_valid; lat counts cycles after the accept edge (1 = next cycle).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    a        = W'($urandom_range(0, 255));
    b        = W'($urandom_range(0, 255));
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [2*W-1:0] er, input int el,
                        input logic ez, input logic ec, input logic ee);
    int lat;
    logic [2*W-1:0] exp_res;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    issue(o, va, vb);
    exp_q.push_back(er);
    wait_result(lat);
    check({tag, "_latency"}, lat, el);
    exp_res = exp_q.pop_front();
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, flag_zero, ez);
    check({tag, "_carry"}, flag_carry, ec);
    check({tag, "_err"}, flag_err, ee);
    @(posedge clk);
    #1;
    check({tag, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = OP_ADD;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_zero, flag_carry, flag_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",     OP_ADD,  8'd200, 8'd100, 16'h002C, 1, 0, 1, 0);
    run_op("add_zero",OP_ADD,  8'd255, 8'd1,   16'h0000, 1, 1, 1, 0);
    run_op("add_nc",  OP_ADD,  8'd20,  8'd30,  16'h0032, 1, 0, 0, 0);
    run_op("sub",     OP_SUB,  8'd5,   8'd7,   16'h00FE, 1, 0, 1, 0);
    run_op("rsub",    OP_RSUB, 8'd5,   8'd7,   16'h0002, 1, 0, 0, 0);
    run_op("and",     OP_AND,  8'hF0,  8'h3C,  16'h0030, 1, 0, 0, 0);
    run_op("or",      OP_OR,   8'hF0,  8'h3C,  16'h00FC, 1, 0, 0, 0);
    run_op("mul",     OP_MUL,  8'd200, 8'd200, 16'h9C40, 9, 0, 0, 0);
    run_op("mul_zero",OP_MUL,  8'd0,   8'd55,  16'h0000, 9, 1, 0, 0);
    run_op("mul_max", OP_MUL,  8'd255, 8'd255, 16'hFE01, 9, 0, 0, 0);
    run_op("div",     OP_DIV,  8'd100, 8'd7,
           DIV_EN ? 16'h020E : 16'h0000, DIV_EN ? 9 : 1, !DIV_EN, 0, !DIV_EN);
    run_op("rdiv",    OP_RDIV, 8'd7,   8'd100,
           DIV_EN ? 16'h020E : 16'h0000, DIV_EN ? 9 : 1, !DIV_EN, 0, !DIV_EN);
    run_op("div0",    OP_DIV,  8'd9,   8'd0,
           DIV_EN ? 16'h09FF : 16'h0000, 1, !DIV_EN, 0, 1);
    run_op("rdiv0",   OP_RDIV, 8'd0,   8'd9,
           DIV_EN ? 16'h09FF : 16'h0000, 1, !DIV_EN, 0, 1);

    // Backpressure: result held, in_valid pulses ignored while DONE.
    out_ready = 1'b0;
    issue(OP_ADD, 8'd250, 8'd10);
    exp_q.push_back(16'h0004);
    wait_result(lat);
    check("bp_latency", lat, 1);
    held = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0];
      op       = OP_MUL;
      a        = 8'hFF;
      b        = 8'hFF;
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, held);
      check("bp_flags", {flag_zero, flag_carry, flag_err}, 3'b010);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("bp_no_ghost", out_valid, 0);

    // Reset during multiply iteration 4.
    issue(OP_MUL, 8'd200, 8'd200);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", OP_MUL, 8'd3, 8'd4, 16'h000C, 9, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
